// File: rtl/par2ser_lanes.sv
// par2ser_lanes: serializes a DATA_WIDTH word over LANES serial outputs, BPL bits per lane.
// Optional one-word holding register for gap-free back-to-back frames: define P2S_DOUBLE_BUFFER_EN.
module par2ser_lanes #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 1,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  en,
  output logic [LANES-1:0]      ser,
  output logic                  bit_valid,
  output logic                  done
);

  localparam int unsigned BPL = DATA_WIDTH / LANES;
  localparam int unsigned CW  = $clog2(BPL) + 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  rdy_q, rdy_d;
  logic                  accept;
  logic                  last;
`ifdef P2S_DOUBLE_BUFFER_EN
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
`endif

  // Advance every lane slice by one bit in the configured direction.
  function automatic logic [DATA_WIDTH-1:0] shift_lanes(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    logic [BPL-1:0]        s;
    r = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      s = w[k*BPL +: BPL];
      s = MSB_FIRST ? (s << 1) : (s >> 1);
      r[k*BPL +: BPL] = s;
    end
    return r;
  endfunction

  assign accept = in_valid && rdy_q;
  assign last   = (cnt_q == CW'(BPL - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef P2S_DOUBLE_BUFFER_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!last) begin
          shreg_d = shift_lanes(shreg_q);
          cnt_d   = cnt_q + CW'(1);
`ifdef P2S_DOUBLE_BUFFER_EN
          if (accept) begin
            hold_d     = in_data;
            hold_vld_d = 1'b1;
          end
`endif
        end else begin
`ifdef P2S_DOUBLE_BUFFER_EN
          // Chain the next frame directly onto the last bit when a word is available.
          if (hold_vld_q) begin
            shreg_d    = hold_q;
            cnt_d      = '0;
            hold_vld_d = 1'b0;
          end else if (accept) begin
            shreg_d = in_data;
            cnt_d   = '0;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
`else
          cnt_d   = '0;
          state_d = S_IDLE;
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    valid_d = (state_d == S_SHIFT);
    done_d  = (state_d == S_SHIFT) && (cnt_d == CW'(BPL - 1));
`ifdef P2S_DOUBLE_BUFFER_EN
    rdy_d   = !hold_vld_d;
`else
    rdy_d   = (state_d == S_IDLE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
`ifdef P2S_DOUBLE_BUFFER_EN
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      rdy_q      <= rdy_d;
`ifdef P2S_DOUBLE_BUFFER_EN
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`endif
    end
  end

  // Lane output taps the leading bit of its slice; en only gates the pins, not the shift.
  always_comb begin
    ser = '0;
    if (valid_q && en) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        ser[k] = MSB_FIRST ? shreg_q[k*BPL + BPL - 1] : shreg_q[k*BPL];
      end
    end
  end

  assign in_ready  = rdy_q;
  assign bit_valid = valid_q;
  assign done      = done_q;

endmodule
